io_vga_param: RTL and testbench

IO_VGA_PARAM -- requirements
Module: io_vga_param

---
 rtl/io_vga_param.sv | 116 +++++++++++
 tb/tb_io_vga_param.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/io_vga_param.sv
// VGA timing generator: free-running h/v counters feeding a two-stage pixel pipeline.
// Stage 1 registers read/addresses/pulses; stage 2 registers colour and delays syncs to match it.
module io_vga_param #(
    parameter int H_SYNC = 96,
    parameter int H_BP   = 48,
    parameter int H_ACT  = 640,
    parameter int H_FP   = 16,
    parameter int V_SYNC = 2,
    parameter int V_BP   = 29,
    parameter int V_ACT  = 480,
    parameter int V_FP   = 10,
    parameter int HS_POL = 0,
    parameter int VS_POL = 0,
    parameter int CW     = 4,
    parameter int AW     = 10
) (
    input  logic            clk,
    input  logic            clrn,
    input  logic            en,
    input  logic [1:0]      scale,
    input  logic [3*CW-1:0] rgb,
    output logic [AW-1:0]   h_addr,
    output logic [AW-1:0]   v_addr,
    output logic            read,
    output logic            frame_start,
    output logic            line_start,
    output logic            vblank,
    output logic            VGA_HS,
    output logic            VGA_VS,
    output logic [CW-1:0]   VGA_R,
    output logic [CW-1:0]   VGA_G,
    output logic [CW-1:0]   VGA_B
);
    localparam int H_TOT = H_SYNC + H_BP + H_ACT + H_FP;
    localparam int V_TOT = V_SYNC + V_BP + V_ACT + V_FP;

    localparam logic [AW-1:0] H_LAST = AW'(H_TOT - 1);
    localparam logic [AW-1:0] V_LAST = AW'(V_TOT - 1);

    // One extra bit so a region end equal to 2^AW still compares correctly.
    localparam logic [AW:0] H_A0   = (AW+1)'(H_SYNC + H_BP);
    localparam logic [AW:0] H_A1   = (AW+1)'(H_SYNC + H_BP + H_ACT);
    localparam logic [AW:0] HS_END = (AW+1)'(H_SYNC);
    localparam logic [AW:0] V_A0   = (AW+1)'(V_SYNC + V_BP);
    localparam logic [AW:0] V_A1   = (AW+1)'(V_SYNC + V_BP + V_ACT);
    localparam logic [AW:0] VS_END = (AW+1)'(V_SYNC);

    localparam logic HS_ON = (HS_POL != 0);
    localparam logic VS_ON = (VS_POL != 0);

    logic [AW-1:0] h_cnt, v_cnt;
    logic [AW-1:0] h_off, v_off;
    logic [1:0]    scale_sh, shift;
    logic          h_act, v_act, in_hs, in_vs;
    logic          hs1, vs1, vb1;

    always_comb begin
        h_act = ({1'b0, h_cnt} >= H_A0) && ({1'b0, h_cnt} < H_A1);
        v_act = ({1'b0, v_cnt} >= V_A0) && ({1'b0, v_cnt} < V_A1);
        in_hs = {1'b0, h_cnt} < HS_END;
        in_vs = {1'b0, v_cnt} < VS_END;
        h_off = h_cnt - H_A0[AW-1:0];
        v_off = v_cnt - V_A0[AW-1:0];
        shift = (scale_sh == 2'd3) ? 2'd0 : scale_sh;
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            h_cnt       <= '0;
            v_cnt       <= '0;
            scale_sh    <= '0;
            read        <= 1'b0;
            h_addr      <= '0;
            v_addr      <= '0;
            frame_start <= 1'b0;
            line_start  <= 1'b0;
            hs1         <= ~HS_ON;
            vs1         <= ~VS_ON;
            vb1         <= 1'b1;
            VGA_HS      <= ~HS_ON;
            VGA_VS      <= ~VS_ON;
            vblank      <= 1'b1;
            VGA_R       <= '0;
            VGA_G       <= '0;
            VGA_B       <= '0;
        end else begin
            // Pulses last one cycle and never survive a stalled edge.
            frame_start <= 1'b0;
            line_start  <= 1'b0;
            if (en) begin
                h_cnt <= (h_cnt == H_LAST) ? '0 : h_cnt + AW'(1);
                if (h_cnt == H_LAST)
                    v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + AW'(1);
                // Scale only changes at the frame boundary so a frame never mixes divisors.
                if (h_cnt == '0 && v_cnt == '0)
                    scale_sh <= scale;

                read        <= h_act && v_act;
                h_addr      <= h_off >> shift;
                v_addr      <= v_off >> shift;
                frame_start <= (h_cnt == '0) && (v_cnt == '0);
                line_start  <= (h_cnt == '0);
                hs1         <= in_hs ? HS_ON : ~HS_ON;
                vs1         <= in_vs ? VS_ON : ~VS_ON;
                vb1         <= ~v_act;

                VGA_R  <= read ? rgb[3*CW-1:2*CW] : '0;
                VGA_G  <= read ? rgb[2*CW-1:CW]   : '0;
                VGA_B  <= read ? rgb[CW-1:0]      : '0;
                VGA_HS <= hs1;
                VGA_VS <= vs1;
                vblank <= vb1;
            end
        end
    end
endmodule

// File: tb/tb_io_vga_param.sv
// Directed bench: small-timing instance A (32x14), polarity instance B (14x7), default instance C.
module tb_io_vga_param;
    logic        clk = 1'b0;
    logic        clrn, en;
    logic [1:0]  scale;
    logic [11:0] rgb;

    logic [9:0] a_h, a_v, b_h, b_v, c_h, c_v;
    logic       a_rd, a_fs, a_ls, a_vb, a_hs, a_vs;
    logic       b_rd, b_fs, b_ls, b_vb, b_hs, b_vs;
    logic       c_rd, c_fs, c_ls, c_vb, c_hs, c_vs;
    logic [3:0] a_r, a_g, a_b, b_r, b_g, b_b, c_r, c_g, c_b;

    int checks = 0;
    int errors = 0;
    int edges  = 0;

    always #5 clk = ~clk;

    io_vga_param #(.H_SYNC(8), .H_BP(4), .H_ACT(16), .H_FP(4),
                   .V_SYNC(2), .V_BP(2), .V_ACT(8), .V_FP(2)) ua (
        .clk(clk), .clrn(clrn), .en(en), .scale(scale), .rgb(rgb),
        .h_addr(a_h), .v_addr(a_v), .read(a_rd), .frame_start(a_fs), .line_start(a_ls),
        .vblank(a_vb), .VGA_HS(a_hs), .VGA_VS(a_vs), .VGA_R(a_r), .VGA_G(a_g), .VGA_B(a_b));

    io_vga_param #(.H_SYNC(2), .H_BP(2), .H_ACT(8), .H_FP(2),
                   .V_SYNC(1), .V_BP(1), .V_ACT(4), .V_FP(1),
                   .HS_POL(1), .VS_POL(1)) ub (
        .clk(clk), .clrn(clrn), .en(en), .scale(scale), .rgb(rgb),
        .h_addr(b_h), .v_addr(b_v), .read(b_rd), .frame_start(b_fs), .line_start(b_ls),
        .vblank(b_vb), .VGA_HS(b_hs), .VGA_VS(b_vs), .VGA_R(b_r), .VGA_G(b_g), .VGA_B(b_b));

    io_vga_param uc (
        .clk(clk), .clrn(clrn), .en(en), .scale(scale), .rgb(rgb),
        .h_addr(c_h), .v_addr(c_v), .read(c_rd), .frame_start(c_fs), .line_start(c_ls),
        .vblank(c_vb), .VGA_HS(c_hs), .VGA_VS(c_vs), .VGA_R(c_r), .VGA_G(c_g), .VGA_B(c_b));

    task automatic step();
        @(posedge clk);
        #1;
        edges++;
    endtask

    task automatic run_to(input int n);
        while (edges < n) step();
    endtask

    task automatic do_reset();
        en = 1'b0; clrn = 1'b0; scale = 2'd0;
        step(); step();
        clrn = 1'b1; en = 1'b1; edges = 0;
    endtask

    task automatic test_reset();
        clrn = 1'b0; en = 1'b0; scale = 2'd0; rgb = 12'hABC;
        #12;
        checks++; if (a_h !== 10'd0 || a_v !== 10'd0) begin errors++; $display("FAIL reset_addr: got h=%0d v=%0d want 0 0", a_h, a_v); end
        checks++; if ({a_rd, a_fs, a_ls} !== 3'b000) begin errors++; $display("FAIL reset_flags: got rd/fs/ls=%b want 000", {a_rd, a_fs, a_ls}); end
        checks++; if ({a_r, a_g, a_b} !== 12'h000) begin errors++; $display("FAIL reset_rgb: got %h want 000", {a_r, a_g, a_b}); end
        checks++; if ({a_hs, a_vs, a_vb} !== 3'b111) begin errors++; $display("FAIL reset_sync_a: got hs/vs/vb=%b want 111", {a_hs, a_vs, a_vb}); end
        checks++; if ({b_hs, b_vs, b_vb} !== 3'b001) begin errors++; $display("FAIL reset_sync_b: got hs/vs/vb=%b want 001", {b_hs, b_vs, b_vb}); end
    endtask

    task automatic test_restart();
        do_reset();
        step();
        checks++; if ({a_fs, a_ls, c_fs} !== 3'b111) begin errors++; $display("FAIL restart_pulse: got a_fs/a_ls/c_fs=%b want 111", {a_fs, a_ls, c_fs}); end
        checks++; if (a_hs !== 1'b1) begin errors++; $display("FAIL restart_hs_e1: got %b want 1", a_hs); end
        step();
        checks++; if ({a_fs, a_ls} !== 2'b00) begin errors++; $display("FAIL restart_pulse_end: got fs/ls=%b want 00", {a_fs, a_ls}); end
        checks++; if (a_hs !== 1'b0) begin errors++; $display("FAIL restart_hs_e2: got %b want 0", a_hs); end
    endtask

    task automatic test_timing();
        int fs = 0, ls = 0, rd = 0, hsl = 0, vsl = 0, vb = 0, fs1 = -1, fs2 = -1;
        do_reset();
        for (int i = 0; i < 896; i++) begin
            step();
            if (a_fs) begin fs++; if (fs1 < 0) fs1 = edges; else if (fs2 < 0) fs2 = edges; end
            ls  += int'(a_ls);
            rd  += int'(a_rd);
            hsl += int'(!a_hs);
            vsl += int'(!a_vs);
            vb  += int'(a_vb);
        end
        checks++; if (fs !== 2) begin errors++; $display("FAIL tim_frames: got %0d want 2", fs); end
        checks++; if (fs2 - fs1 !== 448) begin errors++; $display("FAIL tim_frame_period: got %0d want 448", fs2 - fs1); end
        checks++; if (ls !== 28) begin errors++; $display("FAIL tim_lines: got %0d want 28", ls); end
        checks++; if (rd !== 256) begin errors++; $display("FAIL tim_reads: got %0d want 256", rd); end
        checks++; if (hsl !== 224) begin errors++; $display("FAIL tim_hs_low: got %0d want 224", hsl); end
        checks++; if (vsl !== 128) begin errors++; $display("FAIL tim_vs_low: got %0d want 128", vsl); end
        checks++; if (vb !== 384) begin errors++; $display("FAIL tim_vblank: got %0d want 384", vb); end
    endtask

    task automatic test_polarity();
        int hsh = 0, vsh = 0, rd = 0, ls = 0;
        do_reset();
        for (int i = 0; i < 98; i++) begin
            step();
            hsh += int'(b_hs);
            vsh += int'(b_vs);
            rd  += int'(b_rd);
            ls  += int'(b_ls);
        end
        checks++; if (hsh !== 14) begin errors++; $display("FAIL pol_hs_high: got %0d want 14", hsh); end
        checks++; if (vsh !== 14) begin errors++; $display("FAIL pol_vs_high: got %0d want 14", vsh); end
        checks++; if (rd !== 32) begin errors++; $display("FAIL pol_reads: got %0d want 32", rd); end
        checks++; if (ls !== 7) begin errors++; $display("FAIL pol_lines: got %0d want 7", ls); end
    endtask

    task automatic test_first_pixel();
        do_reset();
        rgb = 12'hABC;
        run_to(129);
        checks++; if (a_vb !== 1'b1) begin errors++; $display("FAIL fp_vblank_e129: got %b want 1", a_vb); end
        run_to(130);
        checks++; if (a_vb !== 1'b0) begin errors++; $display("FAIL fp_vblank_e130: got %b want 0", a_vb); end
        run_to(140);
        checks++; if (a_rd !== 1'b0) begin errors++; $display("FAIL fp_read_early: got %b want 0", a_rd); end
        run_to(141);
        checks++; if ({a_rd, a_h, a_v} !== {1'b1, 10'd0, 10'd0}) begin errors++; $display("FAIL fp_first: got rd=%b h=%0d v=%0d want 1 0 0", a_rd, a_h, a_v); end
        checks++; if ({a_r, a_g, a_b} !== 12'h000) begin errors++; $display("FAIL fp_rgb_same: got %h want 000", {a_r, a_g, a_b}); end
        run_to(142);
        checks++; if ({a_r, a_g, a_b} !== 12'hABC) begin errors++; $display("FAIL fp_rgb_next: got %h want abc", {a_r, a_g, a_b}); end
        run_to(156);
        checks++; if ({a_rd, a_h} !== {1'b1, 10'd15}) begin errors++; $display("FAIL fp_last: got rd=%b h=%0d want 1 15", a_rd, a_h); end
        run_to(157);
        checks++; if (a_rd !== 1'b0) begin errors++; $display("FAIL fp_after_last: got %b want 0", a_rd); end
        run_to(158);
        checks++; if ({a_r, a_g, a_b} !== 12'h000) begin errors++; $display("FAIL fp_rgb_blank: got %h want 000", {a_r, a_g, a_b}); end
    endtask

    task automatic test_scale();
        do_reset();
        run_to(200);
        scale = 2'd1;
        run_to(380);
        checks++; if ({a_h, a_v} !== {10'd15, 10'd7}) begin errors++; $display("FAIL sc_cur_frame: got h=%0d v=%0d want 15 7", a_h, a_v); end
        run_to(588);
        for (int i = 0; i < 16; i++) begin
            step();
            checks++; if ({a_rd, a_h} !== {1'b1, 10'(i >> 1)}) begin errors++; $display("FAIL sc_2x_px%0d: got rd=%b h=%0d want 1 %0d", i, a_rd, a_h, i >> 1); end
        end
        run_to(828);
        checks++; if ({a_h, a_v} !== {10'd7, 10'd3}) begin errors++; $display("FAIL sc_2x_last: got h=%0d v=%0d want 7 3", a_h, a_v); end
        scale = 2'd2;
        run_to(1041);
        checks++; if (a_h !== 10'd1) begin errors++; $display("FAIL sc_4x: got h=%0d want 1", a_h); end
        scale = 2'd0;
    endtask

    task automatic test_en_stall();
        int rd = 0, n = 0;
        do_reset();
        rgb = 12'hABC;
        run_to(172);
        for (int i = 0; i < 6; i++) begin step(); rd += int'(a_rd); end
        checks++; if ({a_h, a_v} !== {10'd5, 10'd1}) begin errors++; $display("FAIL st_pre: got h=%0d v=%0d want 5 1", a_h, a_v); end
        en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            checks++; if ({a_h, a_rd, a_ls, a_fs, a_hs} !== {10'd5, 4'b1001}) begin errors++; $display("FAIL st_frozen%0d: got h=%0d rd/ls/fs/hs=%b want 5 1001", i, a_h, {a_rd, a_ls, a_fs, a_hs}); end
            checks++; if ({a_r, a_g, a_b} !== 12'hABC) begin errors++; $display("FAIL st_rgb%0d: got %h want abc", i, {a_r, a_g, a_b}); end
        end
        en = 1'b1;
        while (n < 40) begin
            step(); n++;
            if (a_ls) break;
            rd += int'(a_rd);
        end
        checks++; if (n !== 15) begin errors++; $display("FAIL st_line_end: got %0d cycles want 15", n); end
        checks++; if (rd !== 16) begin errors++; $display("FAIL st_pixels: got %0d want 16", rd); end
    endtask

    task automatic test_async_reset();
        do_reset();
        rgb = 12'hABC;
        run_to(213);
        checks++; if ({a_rd, a_h, a_v} !== {1'b1, 10'd8, 10'd2}) begin errors++; $display("FAIL ar_pre: got rd=%b h=%0d v=%0d want 1 8 2", a_rd, a_h, a_v); end
        #2 clrn = 1'b0;
        #1;
        checks++; if ({a_rd, a_ls, a_fs, a_h, a_v} !== 23'd0) begin errors++; $display("FAIL ar_outs: got rd=%b h=%0d v=%0d want 0 0 0", a_rd, a_h, a_v); end
        checks++; if ({a_r, a_g, a_b, a_hs, a_vs, a_vb} !== {12'h000, 3'b111}) begin errors++; $display("FAIL ar_rgb_sync: got %h %b want 000 111", {a_r, a_g, a_b}, {a_hs, a_vs, a_vb}); end
        step(); step();
        clrn = 1'b1;
        step();
        checks++; if ({a_fs, a_ls} !== 2'b11) begin errors++; $display("FAIL ar_restart: got fs/ls=%b want 11", {a_fs, a_ls}); end
    endtask

    task automatic test_default();
        int n = 0, hsl = 0, vsl = 0, rd = 0, w = 0;
        do_reset();
        step();
        while (n < 2000) begin
            step(); n++;
            hsl += int'(!c_hs);
            vsl += int'(!c_vs);
            if (c_ls) break;
        end
        checks++; if (n !== 800) begin errors++; $display("FAIL def_line_period: got %0d want 800", n); end
        checks++; if (hsl !== 96) begin errors++; $display("FAIL def_hs_low: got %0d want 96", hsl); end
        checks++; if (vsl !== 800) begin errors++; $display("FAIL def_vs_low: got %0d want 800", vsl); end
        while (!c_rd && w < 30000) begin step(); w++; end
        checks++; if (c_rd !== 1'b1) begin errors++; $display("FAIL def_read_timeout: got read=%b want 1", c_rd); end
        checks++; if ({c_h, c_v} !== 20'd0) begin errors++; $display("FAIL def_first_px: got h=%0d v=%0d want 0 0", c_h, c_v); end
        rd = 1;
        for (int i = 0; i < 799; i++) begin step(); rd += int'(c_rd); end
        checks++; if (rd !== 640) begin errors++; $display("FAIL def_line_reads: got %0d want 640", rd); end
    endtask

    initial begin
        test_reset();
        test_restart();
        test_timing();
        test_polarity();
        test_first_pixel();
        test_scale();
        test_en_stall();
        test_async_reset();
        test_default();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
